fll_cfg_ctrl: RTL and testbench

- Initiator side of the FLL configuration interface; drives fll_bypass / fll_opmode / fll_range / fll_cfgreq into fll_top and consumes fll_lock.
- Accepts frequency-change requests from the chip config/CSR logic over a valid/ready handshake.
- Sequences setup, the cfgreq pulse, and lock acquisition with timeout and retry, then monitors lock loss.
- Sits between the CSR block and fll_top, in the fll_ref_clk domain.

---
 rtl/fll_cfg_pkg.sv | 37 +++
 rtl/fll_cfg_ctrl_if.sv | 47 ++++
 rtl/fll_lock_sync.sv | 27 ++
 rtl/fll_cfg_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fll_cfg_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration controller.
// Holds the sequencer state encoding, the captured configuration record
// and the range codes the CSR side commonly requests.
package fll_cfg_pkg;

   // Sequencer states, from idle through setup, cfgreq pulse, lock wait,
   // then either locked or error.
   typedef enum logic [2:0] {
      IDLE_UNLOCKED = 3'd0,
      SETUP         = 3'd1,
      CFGREQ        = 3'd2,
      WAIT_LOCK     = 3'd3,
      LOCKED        = 3'd4,
      ERROR         = 3'd5
   } fll_state_e;

   // Configuration that is driven to fll_top and held between requests.
   typedef struct packed {
      logic       bypass;
      logic       opmode;
      logic [3:0] range;
   } fll_cfg_t;

   // Range codes for the two standard operating points.
   localparam logic [3:0] RANGE_750M  = 4'h5;
   localparam logic [3:0] RANGE_1500M = 4'h8;

   // Largest of three timing parameters; sizes the shared cycle counter.
   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/fll_cfg_ctrl_if.sv
// CSR-side bus of the FLL configuration controller: the request
// valid/ready handshake with its payload, plus the status flags and
// the sticky-flag clear. The CSR logic is the master, the controller
// is the slave.
interface fll_cfg_ctrl_if;

   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_range;
   logic       req_opmode;
   logic       req_bypass;
   logic       sts_clr;
   logic       sts_busy;
   logic       sts_locked;
   logic       sts_timeout;
   logic       sts_lock_lost;
   logic [1:0] sts_retries;

   modport master (
      output req_valid,
      output req_range,
      output req_opmode,
      output req_bypass,
      output sts_clr,
      input  req_ready,
      input  sts_busy,
      input  sts_locked,
      input  sts_timeout,
      input  sts_lock_lost,
      input  sts_retries
   );

   modport slave (
      input  req_valid,
      input  req_range,
      input  req_opmode,
      input  req_bypass,
      input  sts_clr,
      output req_ready,
      output sts_busy,
      output sts_locked,
      output sts_timeout,
      output sts_lock_lost,
      output sts_retries
   );

endinterface

// File: rtl/fll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous fll_lock indication
// into the reference clock domain. Both flops reset to 0 so a reset
// always reads as "not locked".
module fll_lock_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Shift the async input through two flops to resolve metastability.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/fll_cfg_ctrl.sv
// Initiator side of the FLL configuration interface. Accepts a new
// range/opmode/bypass setting from the CSR side, holds it stable for a
// setup window, pulses cfgreq, then waits for the synchronized lock with
// a timeout and a bounded number of retries. Once locked it watches for
// lock loss and raises a sticky flag without trying to relock.
module fll_cfg_ctrl
   import fll_cfg_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = 4,
   parameter int unsigned CFGREQ_CYCLES = 10,
   parameter int unsigned LOCK_TIMEOUT  = 16384,
   parameter int unsigned MAX_RETRY     = 2,
   parameter logic [3:0]  RESET_RANGE   = 4'h0
) (
   input  logic         fll_ref_clk,
   input  logic         fll_rst,
   fll_cfg_ctrl_if.slave csr,
   output logic         fll_bypass,
   output logic         fll_opmode,
   output logic         fll_cfgreq,
   output logic [3:0]   fll_range,
   input  logic         fll_lock
);

   localparam int CNT_W = $clog2(maxOf3(int'(SETUP_CYCLES), int'(CFGREQ_CYCLES),
                                        int'(LOCK_TIMEOUT))) + 1;

   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CFGREQ_LAST = CNT_W'(CFGREQ_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

   localparam fll_cfg_t RESET_CFG = '{bypass: 1'b0, opmode: 1'b1, range: RESET_RANGE};

   fll_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_retries;
   fll_cfg_t         r_cfg;
   logic             r_cfgreq;
   logic             r_locked;
   logic             r_timeout;
   logic             r_lockLost;

   fll_state_e       w_stateNext;
   logic [CNT_W-1:0] w_cntNext;
   logic [1:0]       w_retriesNext;
   fll_cfg_t         w_cfgNext;
   logic             w_lockedNext;
   logic             w_timeoutSet;
   logic             w_lockLostSet;
   logic             w_lockS;
   logic             w_ready;
   logic             w_transfer;

   fll_lock_sync u_lockSync (
      .i_clk   (fll_ref_clk),
      .i_rst   (fll_rst),
      .i_async (fll_lock),
      .o_sync  (w_lockS)
   );

   assign w_ready    = (r_state == IDLE_UNLOCKED) || (r_state == LOCKED) || (r_state == ERROR);
   assign w_transfer = csr.req_valid && w_ready;

   // Next-state logic: walks setup -> cfgreq -> lock wait with a single
   // shared counter that restarts at 0 on every phase change, so it never
   // needs to wrap. A handshake in any idle-like state restarts the whole
   // sequence and is the only place new configuration is captured.
   always_comb begin
      w_stateNext   = r_state;
      w_cntNext     = r_cnt;
      w_retriesNext = r_retries;
      w_cfgNext     = r_cfg;
      w_lockedNext  = r_locked;
      w_timeoutSet  = 1'b0;
      w_lockLostSet = 1'b0;

      case (r_state)
         IDLE_UNLOCKED, LOCKED, ERROR: begin
            if ((r_state == LOCKED) && !r_cfg.bypass && r_locked && !w_lockS) begin
               w_lockedNext  = 1'b0;
               w_lockLostSet = 1'b1;
            end
            if (w_transfer) begin
               w_stateNext   = SETUP;
               w_cntNext     = '0;
               w_retriesNext = 2'd0;
               w_lockedNext  = 1'b0;
               w_cfgNext     = '{bypass: csr.req_bypass,
                                 opmode: csr.req_opmode,
                                 range:  csr.req_range};
            end
         end

         SETUP: begin
            if (r_cnt == SETUP_LAST) begin
               w_stateNext = CFGREQ;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end

         CFGREQ: begin
            if (r_cnt == CFGREQ_LAST) begin
               w_stateNext = WAIT_LOCK;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end

         WAIT_LOCK: begin
            if (r_cfg.bypass) begin
               w_stateNext = LOCKED;
            end else if (w_lockS) begin
               w_stateNext  = LOCKED;
               w_lockedNext = 1'b1;
            end else if (r_cnt == LOCK_LAST) begin
               w_cntNext = '0;
               if (r_retries < RETRY_MAX) begin
                  w_retriesNext = r_retries + 2'd1;
                  w_stateNext   = SETUP;
               end else begin
                  w_stateNext  = ERROR;
                  w_timeoutSet = 1'b1;
               end
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end

         default: begin
            w_stateNext = IDLE_UNLOCKED;
            w_cntNext   = '0;
         end
      endcase
   end

   // State and status registers. cfgreq is registered from the next state
   // so the pulse to fll_top is glitch-free and drops with reset. Sticky
   // flags give a same-cycle set priority over the clear.
   always_ff @(posedge fll_ref_clk or posedge fll_rst) begin
      if (fll_rst) begin
         r_state    <= IDLE_UNLOCKED;
         r_cnt      <= '0;
         r_retries  <= 2'd0;
         r_cfg      <= RESET_CFG;
         r_cfgreq   <= 1'b0;
         r_locked   <= 1'b0;
         r_timeout  <= 1'b0;
         r_lockLost <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_retries  <= w_retriesNext;
         r_cfg      <= w_cfgNext;
         r_cfgreq   <= (w_stateNext == CFGREQ);
         r_locked   <= w_lockedNext;
         r_timeout  <= w_timeoutSet | (r_timeout & ~csr.sts_clr);
         r_lockLost <= w_lockLostSet | (r_lockLost & ~csr.sts_clr);
      end
   end

   assign fll_bypass = r_cfg.bypass;
   assign fll_opmode = r_cfg.opmode;
   assign fll_range  = r_cfg.range;
   assign fll_cfgreq = r_cfgreq;

   assign csr.req_ready     = w_ready;
   assign csr.sts_busy      = (r_state == SETUP) || (r_state == CFGREQ) || (r_state == WAIT_LOCK);
   assign csr.sts_locked    = r_locked;
   assign csr.sts_timeout   = r_timeout;
   assign csr.sts_lock_lost = r_lockLost;
   assign csr.sts_retries   = r_retries;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Directed bench for fll_cfg_ctrl. Plays the CSR side through the
// interface and models fll_top's lock output by hand. Uses a short lock
// timeout so the full retry/timeout path fits in a few hundred cycles.
module tb_fll_cfg_ctrl;
   import fll_cfg_pkg::*;

   localparam int unsigned TB_LOCK_TIMEOUT = 64;

   logic       fll_ref_clk;
   logic       fll_rst;
   logic       fll_bypass;
   logic       fll_opmode;
   logic       fll_cfgreq;
   logic [3:0] fll_range;
   logic       fll_lock;

   int assertCount;
   int failCount;
   int cycles;
   int pulses;
   int readyViolations;
   logic prevCfgreq;

   fll_cfg_ctrl_if csrIf ();

   fll_cfg_ctrl #(
      .SETUP_CYCLES  (4),
      .CFGREQ_CYCLES (10),
      .LOCK_TIMEOUT  (TB_LOCK_TIMEOUT),
      .MAX_RETRY     (2),
      .RESET_RANGE   (4'h0)
   ) dut (
      .fll_ref_clk (fll_ref_clk),
      .fll_rst     (fll_rst),
      .csr         (csrIf),
      .fll_bypass  (fll_bypass),
      .fll_opmode  (fll_opmode),
      .fll_cfgreq  (fll_cfgreq),
      .fll_range   (fll_range),
      .fll_lock    (fll_lock)
   );

   // Free-running reference clock, 10 ns period.
   initial begin
      fll_ref_clk = 1'b0;
      forever #5 fll_ref_clk = ~fll_ref_clk;
   end

   // Advance one clock and settle just past the edge before sampling.
   task automatic tick();
      @(posedge fll_ref_clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one request for a single cycle; returns just after the
   // transfer edge.
   task automatic applyStimulus(input logic [3:0] range, input logic opmode,
                                input logic bypass);
      csrIf.req_range  = range;
      csrIf.req_opmode = opmode;
      csrIf.req_bypass = bypass;
      csrIf.req_valid  = 1'b1;
      tick();
      csrIf.req_valid  = 1'b0;
   endtask

   // Linear sequence of directed steps covering reset, lock, relock,
   // lock loss, timeout with retries, bypass and mid-sequence reset.
   initial begin
      assertCount      = 0;
      failCount        = 0;
      fll_rst          = 1'b1;
      fll_lock         = 1'b0;
      csrIf.req_valid  = 1'b0;
      csrIf.req_range  = 4'h0;
      csrIf.req_opmode = 1'b0;
      csrIf.req_bypass = 1'b0;
      csrIf.sts_clr    = 1'b0;

      repeat (10) tick();
      checkOutput("rst_range",   32'(fll_range), 32'h0);
      checkOutput("rst_opmode",  32'(fll_opmode), 32'h1);
      checkOutput("rst_bypass",  32'(fll_bypass), 32'h0);
      checkOutput("rst_cfgreq",  32'(fll_cfgreq), 32'h0);
      checkOutput("rst_ready",   32'(csrIf.req_ready), 32'h1);
      checkOutput("rst_busy",    32'(csrIf.sts_busy), 32'h0);
      checkOutput("rst_locked",  32'(csrIf.sts_locked), 32'h0);
      checkOutput("rst_timeout", 32'(csrIf.sts_timeout), 32'h0);
      checkOutput("rst_lost",    32'(csrIf.sts_lock_lost), 32'h0);
      checkOutput("rst_retries", 32'(csrIf.sts_retries), 32'h0);
      fll_rst = 1'b0;
      tick();

      // First lock at 750M: 4 setup cycles, 10 cfgreq cycles, lock after 40.
      applyStimulus(RANGE_750M, 1'b1, 1'b0);
      checkOutput("A_range",  32'(fll_range), 32'h5);
      checkOutput("A_ready",  32'(csrIf.req_ready), 32'h0);
      checkOutput("A_busy",   32'(csrIf.sts_busy), 32'h1);
      checkOutput("A_cfgreq", 32'(fll_cfgreq), 32'h0);
      cycles = 0;
      while (!fll_cfgreq && cycles < 50) begin
         tick();
         cycles++;
      end
      checkOutput("A_setupCycles", cycles, 4);
      cycles = 0;
      while (fll_cfgreq && cycles < 50) begin
         tick();
         cycles++;
      end
      checkOutput("A_cfgreqHigh", cycles, 10);
      repeat (40) tick();
      checkOutput("A_waitBusy",    32'(csrIf.sts_busy), 32'h1);
      checkOutput("A_waitRetries", 32'(csrIf.sts_retries), 32'h0);
      fll_lock = 1'b1;
      cycles = 0;
      while (!csrIf.sts_locked && cycles < 20) begin
         tick();
         cycles++;
      end
      checkOutput("A_lockLatency", cycles, 3);
      checkOutput("A_busyDone",    32'(csrIf.sts_busy), 32'h0);
      checkOutput("A_readyDone",   32'(csrIf.req_ready), 32'h1);
      checkOutput("A_retries",     32'(csrIf.sts_retries), 32'h0);

      // Relock at 1500M from LOCKED; lock model drops, returns at cycle 30.
      fll_lock = 1'b0;
      applyStimulus(RANGE_1500M, 1'b1, 1'b0);
      checkOutput("B_lockedDrop", 32'(csrIf.sts_locked), 32'h0);
      checkOutput("B_range",      32'(fll_range), 32'h8);
      checkOutput("B_ready",      32'(csrIf.req_ready), 32'h0);
      cycles = 0;
      readyViolations = 0;
      while (!csrIf.sts_locked && cycles < 200) begin
         tick();
         cycles++;
         if (csrIf.req_ready && !csrIf.sts_locked) readyViolations++;
         if (cycles == 30) fll_lock = 1'b1;
      end
      checkOutput("B_relockCycles",   cycles, 33);
      checkOutput("B_readyDuringSeq", readyViolations, 0);
      checkOutput("B_lostClean",      32'(csrIf.sts_lock_lost), 32'h0);

      // Lock loss while LOCKED: flag appears once the synchronized drop is seen.
      fll_lock = 1'b0;
      repeat (2) tick();
      checkOutput("C_lostNotYet", 32'(csrIf.sts_lock_lost), 32'h0);
      tick();
      checkOutput("C_lost",         32'(csrIf.sts_lock_lost), 32'h1);
      checkOutput("C_lockedCleared", 32'(csrIf.sts_locked), 32'h0);
      checkOutput("C_stayLocked",   32'(csrIf.req_ready), 32'h1);
      csrIf.sts_clr = 1'b1;
      tick();
      csrIf.sts_clr = 1'b0;
      checkOutput("C_lostCleared", 32'(csrIf.sts_lock_lost), 32'h0);

      // Never locks: three attempts of 4+10+64 cycles, clear held high so
      // the set-beats-clear priority shows up on the final timeout edge.
      applyStimulus(RANGE_750M, 1'b0, 1'b0);
      csrIf.sts_clr = 1'b1;
      cycles = 0;
      pulses = 0;
      prevCfgreq = 1'b0;
      while (csrIf.sts_busy && cycles < 1000) begin
         tick();
         cycles++;
         if (fll_cfgreq && !prevCfgreq) pulses++;
         prevCfgreq = fll_cfgreq;
      end
      checkOutput("D_pulses",    pulses, 3);
      checkOutput("D_cycles",    cycles, 234);
      checkOutput("D_timeout",   32'(csrIf.sts_timeout), 32'h1);
      checkOutput("D_retries",   32'(csrIf.sts_retries), 32'h2);
      checkOutput("D_ready",     32'(csrIf.req_ready), 32'h1);
      checkOutput("D_rangeHeld", 32'(fll_range), 32'h5);
      checkOutput("D_opmode",    32'(fll_opmode), 32'h0);
      tick();
      csrIf.sts_clr = 1'b0;
      checkOutput("D_timeoutCleared", 32'(csrIf.sts_timeout), 32'h0);
      checkOutput("D_retriesKept",    32'(csrIf.sts_retries), 32'h2);

      // Bypass request from ERROR: goes LOCKED without any lock indication.
      applyStimulus(RANGE_1500M, 1'b1, 1'b1);
      cycles = 0;
      while (csrIf.sts_busy && cycles < 100) begin
         tick();
         cycles++;
      end
      checkOutput("E_cycles",  cycles, 15);
      checkOutput("E_bypass",  32'(fll_bypass), 32'h1);
      checkOutput("E_ready",   32'(csrIf.req_ready), 32'h1);
      checkOutput("E_locked",  32'(csrIf.sts_locked), 32'h0);
      checkOutput("E_retries", 32'(csrIf.sts_retries), 32'h0);
      repeat (5) tick();
      checkOutput("E_noLost",  32'(csrIf.sts_lock_lost), 32'h0);

      // Reset in the middle of the cfgreq pulse aborts immediately.
      applyStimulus(RANGE_750M, 1'b0, 1'b0);
      cycles = 0;
      while (!fll_cfgreq && cycles < 50) begin
         tick();
         cycles++;
      end
      checkOutput("F_cfgreqUp", 32'(fll_cfgreq), 32'h1);
      repeat (3) tick();
      #2;
      fll_rst = 1'b1;
      #1;
      checkOutput("F_cfgreq", 32'(fll_cfgreq), 32'h0);
      checkOutput("F_range",  32'(fll_range), 32'h0);
      checkOutput("F_opmode", 32'(fll_opmode), 32'h1);
      checkOutput("F_bypass", 32'(fll_bypass), 32'h0);
      checkOutput("F_ready",  32'(csrIf.req_ready), 32'h1);
      checkOutput("F_busy",   32'(csrIf.sts_busy), 32'h0);
      fll_rst = 1'b0;
      repeat (3) tick();
      checkOutput("F_idleAfter", 32'(fll_cfgreq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
